// File: rtl/spi_word_rx.sv
// SPI slave word receiver.
// Oversamples sclk/mosi/ncs in the clk domain and assembles WIDTH-bit MSB-first
// frames. It gives a one-cycle valid pulse per good frame and a one-cycle
// frameErr pulse per malformed frame (short, stalled or overrun).
// Pipeline: synchronizers -> registered edge detect -> FSM -> registered outputs.
module spi_word_rx #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ncs,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             frameErr,
    output logic             busy,
    output logic [15:0]      frameCount
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SYNC_STAGES + 2);

    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
    // Synchronizer chain plus the edge-detect flop must hold real samples
    // before ncs may arm a frame; the reset value of ncs is not a real "high".
    localparam logic [SW-1:0] SETTLE_C  = SW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Synchronizers and edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_prev_q;
    logic                   ncs_prev_q;
    logic [SW-1:0]          settle_q;
    logic                   armed_q;
    logic                   sclk_rise_q;
    logic                   ncs_fall_q;
    logic                   ncs_rise_q;
    logic                   mosi_bit_q;

    logic sclk_s;
    logic mosi_s;
    logic ncs_s;
    logic settled_s;

    // Frame FSM and datapath.
    state_t           state_q,   state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [TW-1:0]    timer_q,   timer_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word_q,    word_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic [15:0]      count_q,   count_d;
    logic [WIDTH-1:0] shift_new_s;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign settled_s = (settle_q == SETTLE_C);

    // Input synchronizers, delayed copies and the settle counter after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            ncs_sync_q  <= {SYNC_STAGES{1'b1}};
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            settle_q    <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
            if (!settled_s) begin
                settle_q <= settle_q + SW'(1);
            end else begin
                settle_q <= settle_q;
            end
        end
    end

    // Registered edge strobes, the data bit aligned with them, and arming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_rise_q <= 1'b0;
            ncs_fall_q  <= 1'b0;
            ncs_rise_q  <= 1'b0;
            mosi_bit_q  <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            ncs_fall_q  <= ~ncs_s & ncs_prev_q;
            ncs_rise_q  <= ncs_s & ~ncs_prev_q;
            mosi_bit_q  <= mosi_s;
            armed_q     <= armed_q | (ncs_s & settled_s);
        end
    end

    assign shift_new_s = {shift_q[WIDTH-2:0], mosi_bit_q};

    // Next-state and datapath logic; an sclk edge is handled before an ncs
    // rise in the same cycle, and an ncs rise beats the stall timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        timer_d   = timer_q;
        overrun_d = overrun_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                overrun_d = 1'b0;
                if (ncs_fall_q && armed_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    timer_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (sclk_rise_q) begin
                    shift_d   = shift_new_s;
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    timer_d   = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        word_d  = shift_new_s;
                        valid_d = 1'b1;
                        count_d = count_q + 16'd1;
                        state_d = ncs_rise_q ? IDLE : FULL;
                    end else if (ncs_rise_q) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (ncs_rise_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = FULL;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FULL: begin
                if (ncs_rise_q) begin
                    err_d     = overrun_q | sclk_rise_q;
                    overrun_d = 1'b0;
                    state_d   = IDLE;
                end else if (sclk_rise_q) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            default: begin
                state_d   = IDLE;
                overrun_d = 1'b0;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            timer_q   <= '0;
            overrun_q <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            timer_q   <= timer_d;
            overrun_q <= overrun_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    // Output register stage; word and valid move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word       <= '0;
            valid      <= 1'b0;
            frameErr   <= 1'b0;
            busy       <= 1'b0;
            frameCount <= 16'd0;
        end else begin
            word       <= word_q;
            valid      <= valid_q;
            frameErr   <= err_q;
            busy       <= (state_q == SHIFT) || (state_q == FULL);
            frameCount <= count_q;
        end
    end

endmodule

// File: tb/tb_spi_word_rx.sv
// Self-checking bench for spi_word_rx: table of frames plus hand-written
// stall, reset and simultaneous-edge sequences, with a pulse scoreboard.
module tb_spi_word_rx;

    localparam int WIDTH = 10;
    localparam int SYNC  = 2;
    localparam int HALF  = 32;   // sclk = clk/64
    localparam int GAP   = 128;  // two sclk periods with ncs high

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        ncs;
    logic [9:0]  word;
    logic        valid;
    logic        frameErr;
    logic        busy;
    logic [15:0] frameCount;

    spi_word_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ncs(ncs),
        .word(word), .valid(valid), .frameErr(frameErr), .busy(busy),
        .frameCount(frameCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] bits;
        int          nbits;
        bit          exp_valid;
        logic [9:0]  exp_word;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit         is_err;
        logic [9:0] w;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         rise_cyc = 0;
    int         bits_sent = 0;
    int         model_count = 0;
    logic [9:0] last_word = 10'h000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (!reset && (valid || frameErr)) begin
            check("pulse_exclusive", {31'd0, valid & frameErr}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got valid=%0b frameErr=%0b word=%0h, expected no pulse (t=%0t)",
                         valid, frameErr, word, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_is_err", {31'd0, frameErr}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("valid_word", {22'd0, word}, {22'd0, e.w});
                    // edge that sampled sclk high for bit 10 -> SYNC+2 edges later
                    check("valid_latency", cyc - rise_cyc, SYNC + 2);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        bits_sent++;
        if (bits_sent == WIDTH) rise_cyc = cyc + 1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] bits, input int nbits);
        ncs = 1'b0;
        bits_sent = 0;
        for (int i = nbits - 1; i >= 0; i--) send_bit(bits[i]);
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic expect_good(input logic [9:0] w);
        ev_t e;
        e.is_err = 1'b0;
        e.w = w;
        exp_q.push_back(e);
        model_count++;
        last_word = w;
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.w = 10'h000;
        exp_q.push_back(e);
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_word"}, {22'd0, word}, {22'd0, last_word});
        check({tag, "_count"}, {16'd0, frameCount}, model_count);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{"good_2A5",    16'h02A5, 10, 1'b1, 10'h2A5, 1'b0};
        vecs[1] = '{"b2b_3FF",     16'h03FF, 10, 1'b1, 10'h3FF, 1'b0};
        vecs[2] = '{"b2b_000",     16'h0000, 10, 1'b1, 10'h000, 1'b0};
        vecs[3] = '{"b2b_155",     16'h0155, 10, 1'b1, 10'h155, 1'b0};
        vecs[4] = '{"short6",      16'h002D,  6, 1'b0, 10'h000, 1'b1};
        vecs[5] = '{"overrun12",   16'h0ABC, 12, 1'b1, 10'h2AF, 1'b1};

        reset = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        ncs   = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_word", {22'd0, word}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frameErr", {31'd0, frameErr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {16'd0, frameCount}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Table of whole frames.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].exp_valid) expect_good(vecs[i].exp_word);
            if (vecs[i].exp_err) expect_err();
            send_frame(vecs[i].bits, vecs[i].nbits);
            check_idle_state(vecs[i].name);
        end

        // Stall: 4 bits then sclk low; timeout error, then silence until ncs rises.
        expect_err();
        ncs = 1'b0;
        bits_sent = 0;
        for (int i = 3; i >= 0; i--) send_bit(i[0]);
        repeat (900) @(negedge clk);
        check("stall_not_early", exp_q.size(), 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd1);
        repeat (200) @(negedge clk);
        check("stall_err_seen", exp_q.size(), 32'd0);
        check("stall_busy_full", {31'd0, busy}, 32'd1);
        ncs = 1'b1;
        repeat (GAP) @(negedge clk);
        check_idle_state("stall_end");
        expect_good(10'h1C3);
        send_frame(16'h01C3, 10);
        check_idle_state("after_stall_1C3");

        // Reset after bit 5, released with ncs still low, frame finished.
        ncs = 1'b0;
        bits_sent = 0;
        for (int i = 9; i >= 5; i--) send_bit(i[0]);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.delete();
        model_count = 0;
        last_word = 10'h000;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_count", {16'd0, frameCount}, 32'd0);
        reset = 1'b0;
        for (int i = 4; i >= 0; i--) send_bit(i[0]);
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        repeat (GAP) @(negedge clk);
        check_idle_state("after_reset_partial");
        expect_good(10'h0F0);
        send_frame(16'h00F0, 10);
        check_idle_state("after_reset_0F0");

        // ncs rises in the same clk as sclk edge 10: accepted, no error.
        expect_good(10'h16D);
        ncs = 1'b0;
        bits_sent = 0;
        for (int i = 9; i >= 1; i--) send_bit(((16'h016D >> i) & 16'h1) != 16'h0);
        mosi = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        ncs  = 1'b1;
        bits_sent++;
        rise_cyc = cyc + 1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        repeat (GAP) @(negedge clk);
        check_idle_state("same_clk_edge");
        expect_good(10'h0A5);
        send_frame(16'h00A5, 10);
        check_idle_state("after_same_clk");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
